// File: rtl/instr_encoder.sv
// instr_encoder: packs operation descriptors into 16-bit Tron instruction words, expanding
// out-of-range immediates via LUI/ORI through a scratch register. Option: INSTR_ENC_STATS_EN.
module instr_encoder #(
  parameter int unsigned SCRATCH_REG = 15,
  parameter int unsigned WIDTH       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [3:0]       in_rd,
  input  logic [3:0]       in_rs,
  input  logic [3:0]       in_cond,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] instr,
  output logic             out_last,
  output logic             err
`ifdef INSTR_ENC_STATS_EN
  ,
  output logic [15:0]      word_count,
  output logic [7:0]       err_count
`endif
);

  localparam logic [4:0] OpAdd   = 5'd0;
  localparam logic [4:0] OpSub   = 5'd1;
  localparam logic [4:0] OpCmp   = 5'd2;
  localparam logic [4:0] OpAnd   = 5'd3;
  localparam logic [4:0] OpOr    = 5'd4;
  localparam logic [4:0] OpXor   = 5'd5;
  localparam logic [4:0] OpMov   = 5'd6;
  localparam logic [4:0] OpLsh   = 5'd7;
  localparam logic [4:0] OpAddi  = 5'd8;
  localparam logic [4:0] OpSubi  = 5'd9;
  localparam logic [4:0] OpCmpi  = 5'd10;
  localparam logic [4:0] OpAndi  = 5'd11;
  localparam logic [4:0] OpOri   = 5'd12;
  localparam logic [4:0] OpXori  = 5'd13;
  localparam logic [4:0] OpMovi  = 5'd14;
  localparam logic [4:0] OpLshi  = 5'd15;
  localparam logic [4:0] OpLui   = 5'd16;
  localparam logic [4:0] OpLoad  = 5'd17;
  localparam logic [4:0] OpStor  = 5'd18;
  localparam logic [4:0] OpJal   = 5'd19;
  localparam logic [4:0] OpBcond = 5'd20;
  localparam logic [4:0] OpJcond = 5'd21;

  localparam logic [3:0] MajR     = 4'b0000;
  localparam logic [3:0] MajShift = 4'b1000;
  localparam logic [3:0] MajMem   = 4'b0100;
  localparam logic [3:0] MajBcond = 4'b1100;
  localparam logic [3:0] OpcLui   = 4'b1111;
  localparam logic [3:0] OpcOri   = 4'b0010;
  localparam logic [3:0] Scratch  = 4'(SCRATCH_REG);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  // Shared ALU code: R-type ext field and I-type opcode use the same value per operation.
  function automatic logic [3:0] alu_code(input logic [2:0] sel);
    logic [3:0] code;
    case (sel)
      3'd0:    code = 4'b0101;
      3'd1:    code = 4'b1001;
      3'd2:    code = 4'b1011;
      3'd3:    code = 4'b0001;
      3'd4:    code = 4'b0010;
      3'd5:    code = 4'b0011;
      default: code = 4'b1101;
    endcase
    return code;
  endfunction

  // Descriptor encoding, evaluated on the live inputs and captured at acceptance.
  logic [WIDTH-1:0] enc_word [3];
  logic [1:0]       enc_count;
  logic             enc_reject;
  logic [7:0]       imm_hi, imm_lo;
  logic             fits_s8, fits_u8, fits_s5, imm_fits;
  logic [3:0]       alu;

  assign imm_hi  = in_imm[WIDTH-1:8];
  assign imm_lo  = in_imm[7:0];
  assign fits_s8 = (in_imm[WIDTH-1:7] == '0) || (in_imm[WIDTH-1:7] == '1);
  assign fits_u8 = (in_imm[WIDTH-1:8] == '0);
  assign fits_s5 = (in_imm[WIDTH-1:4] == '0) || (in_imm[WIDTH-1:4] == '1);

  always_comb begin
    enc_word[0] = '0;
    enc_word[1] = '0;
    enc_word[2] = '0;
    enc_count   = 2'd1;
    enc_reject  = 1'b0;
    alu         = alu_code(in_op[2:0]);
    imm_fits    = (in_op inside {OpAddi, OpSubi, OpCmpi}) ? fits_s8 : fits_u8;
    case (in_op)
      OpAdd, OpSub, OpCmp, OpAnd, OpOr, OpXor, OpMov: begin
        enc_word[0] = {MajR, in_rd, alu, in_rs};
      end
      OpLsh: enc_word[0] = {MajShift, in_rd, 4'b0100, in_rs};
      OpAddi, OpSubi, OpCmpi, OpAndi, OpOri, OpXori, OpMovi: begin
        if (imm_fits) begin
          enc_word[0] = {alu, in_rd, imm_lo};
        end else if (in_rd == Scratch) begin
          enc_reject = 1'b1;
        end else if (in_op == OpMovi) begin
          // MOVI builds the value directly in rd, no scratch needed.
          enc_word[0] = {OpcLui, in_rd, imm_hi};
          enc_word[1] = {OpcOri, in_rd, imm_lo};
          enc_count   = (imm_lo == '0) ? 2'd1 : 2'd2;
        end else begin
          enc_word[0] = {OpcLui, Scratch, imm_hi};
          if (imm_lo == '0) begin
            enc_word[1] = {MajR, in_rd, alu, Scratch};
            enc_count   = 2'd2;
          end else begin
            enc_word[1] = {OpcOri, Scratch, imm_lo};
            enc_word[2] = {MajR, in_rd, alu, Scratch};
            enc_count   = 2'd3;
          end
        end
      end
      OpLshi: begin
        if (fits_s5) enc_word[0] = {MajShift, in_rd, 3'b000, in_imm[4:0]};
        else         enc_reject  = 1'b1;
      end
      OpLui:  enc_word[0] = {OpcLui, in_rd, imm_lo};
      OpLoad: enc_word[0] = {MajMem, in_rd, 4'b0000, in_rs};
      OpStor: enc_word[0] = {MajMem, in_rd, 4'b0100, in_rs};
      OpJal:  enc_word[0] = {MajMem, in_rd, 4'b1000, in_rs};
      OpBcond: begin
        if (fits_s8) enc_word[0] = {MajBcond, in_cond, imm_lo};
        else         enc_reject  = 1'b1;
      end
      OpJcond: enc_word[0] = {MajMem, in_cond, 4'b1100, in_rs};
      default: enc_reject = 1'b1;
    endcase
  end

  // Emission FSM and word buffer.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] buf_q [3];
  logic [WIDTH-1:0] buf_d [3];
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       count_q, count_d;
  logic             err_q, err_d;
  logic             last_word;

  assign last_word = (idx_q == count_q - 2'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (enc_reject) begin
            err_d = 1'b1;
          end else begin
            buf_d   = enc_word;
            count_d = enc_count;
            idx_d   = 2'd0;
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (last_word) state_d = StIdle;
          else           idx_d   = idx_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      buf_q   <= '{default: '0};
      idx_q   <= 2'd0;
      count_q <= 2'd1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StEmit);
    instr     = out_valid ? buf_q[idx_q] : '0;
    out_last  = out_valid && last_word;
    err       = err_q;
  end

`ifdef INSTR_ENC_STATS_EN
  logic [15:0] word_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (out_valid && out_ready) word_cnt_q <= word_cnt_q + 16'd1;
      if (err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign word_count = word_cnt_q;
  assign err_count  = err_cnt_q;
`endif

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Packs structured operation descriptors into 16-bit Tron instruction words, one word per accepted handshake. It is the inverse of the multicycle controller's fetch/decode. Immediates that do not fit the 8-bit field are expanded into LUI/ORI sequences through a scratch register. It feeds the boot/debug instruction-injection path, which writes words into instruction memory or the fetch stream.

Parameters:
SCRATCH_REG, 15, register index used for out-of-range immediate expansion.
WIDTH, 16, instruction and immediate width; fixed at 16.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  descriptor valid
in_ready  out  1  encoder can accept a descriptor
in_op  in  5  operation enum (see Behaviour)
in_rd  in  4  destination/link/source-data register
in_rs  in  4  source/address/target/shift-amount register
in_cond  in  4  condition code for BCOND/JCOND
in_imm  in  16  immediate, displacement or shift amount (two's complement where signed)
out_valid  out  1  instr holds a valid word
out_ready  in  1  consumer accepts the word
instr  out  16  encoded word
out_last  out  1  final word of the current descriptor
err  out  1  one-cycle pulse: descriptor rejected

Behaviour:
- Reset (reset==0 at posedge clk) gives: state IDLE, instr=0, out_valid=0, out_last=0, err=0, in_ready=1. Reset mid-sequence discards the remaining words.
- in_op enum: 0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 LSH, 8 ADDI, 9 SUBI, 10 CMPI, 11 ANDI, 12 ORI, 13 XORI, 14 MOVI, 15 LSHI, 16 LUI, 17 LOAD, 18 STOR, 19 JAL, 20 BCOND, 21 JCOND. Values 22-31 are illegal.
- R-type words are {0000, rd, ext, rs}. ext values: ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101.
- I-type words are {op, rd, imm[7:0]}. op values: ADDI 0101, SUBI 1001, CMPI 1011, ANDI 0001, ORI 0010, XORI 0011, MOVI 1101, LUI 1111.
- Other formats:
  - LSH {1000, rd, 0100, rs}
  - LSHI {1000, rd, 000, amt[4:0]}
  - LOAD {0100, rd, 0000, rs}
  - STOR {0100, rd, 0100, rs}
  - JAL {0100, rd, 1000, rs}
  - BCOND {1100, cond, disp[7:0]}
  - JCOND {0100, cond, 1100, rs}
- Immediate fit rules:
  - ADDI/SUBI/CMPI fit when signed imm is in -128..127.
  - ANDI/ORI/XORI/MOVI fit when imm is in 0..255.
  - LUI emits imm[7:0]; imm[15:8] is ignored.
- Expansion of a non-fitting MOVI: LUI rd,hi; then ORI rd,lo. The ORI is omitted when lo==0.
- Expansion of other non-fitting I-ops: LUI SCRATCH,hi; ORI SCRATCH,lo (omitted if lo==0); then the R-type equivalent rd,SCRATCH.
- Rejection (err pulses one cycle, no word emitted, in_ready stays 1) in these cases:
  - illegal op;
  - LSHI amount outside -16..15;
  - BCOND displacement outside -128..127;
  - expansion required while rd==SCRATCH_REG.
- FSM states:
  - IDLE: in_ready=1. On in_valid, the descriptor is latched, the 1-3 words are computed into buffer registers, and the FSM moves to EMIT with index 0. Otherwise it stays in IDLE.
  - EMIT: in_ready=0, out_valid=1, instr=buffer[index], out_last=(index==count-1).
  - EMIT transitions: on out_valid&&out_ready, the index increments; after the last word the FSM returns to IDLE and out_valid drops.
- Latency: the first word is valid the cycle after acceptance. With out_ready held high, one word is emitted per cycle. The next descriptor is accepted no earlier than the cycle after the last word.
- While out_ready==0, instr and out_last hold stable.
- Inputs are sampled only at acceptance.

Optional Feature:
INSTR_ENC_STATS_EN.
- Defined: adds outputs word_count[15:0] and err_count[7:0].
  - word_count increments on each out_valid&&out_ready and wraps at 16 bits.
  - err_count increments on each err pulse and saturates at 255.
  - Both counters clear on reset.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Test Plan:
1. ADD rd=3 rs=4, out_ready=1 -> single word 0x0354, out_last=1, out_valid high for exactly 1 cycle.
2. ADDI rd=2 imm=0xFFFB -> 0x52FB, out_last=1. MOVI rd=1 imm=0x00FF -> 0xD1FF.
3. MOVI rd=1 imm=0x1234 -> 0xF112 then 0x2134 (out_last on the second word). MOVI rd=1 imm=0x1200 -> 0xF112 only, out_last=1.
4. ADDI rd=2 imm=0x0345, out_ready low for 2 cycles after the first word -> 0xFF03 held stable, then 0x2F45, then 0x025F with out_last; in_ready=0 throughout.
5. BCOND cond=1 imm=0xFFFE -> 0xC1FE. BCOND imm=200 -> err pulse, no out_valid. ADDI rd=15 imm=0x0300 -> err. in_op=25 -> err.
6. Reset asserted after the first word of the 3-word sequence in 4 -> next cycle out_valid=0, instr=0, in_ready=1. A new LSHI rd=5 imm=0xFFFF (-1) then encodes to 0x851F.
